// File: rtl/bcd2_down_timer_if.sv
// Control/status bundle for the two-digit BCD countdown timer.
// The master drives the count/load/start/stop requests; the slave returns the count and status.
interface bcd2_down_timer_if;
  logic       x;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic [7:0] bcd2_out;
  logic       running;
  logic       done;

  modport master (
    output x, load, load_val, start, stop,
    input  bcd2_out, running, done
  );

  modport slave (
    input  x, load, load_val, start, stop,
    output bcd2_out, running, done
  );
endinterface

// File: rtl/bcd2_down_timer.sv
// Two-digit packed-BCD countdown timer with load, start/stop and a one-cycle done pulse.
//
// state | meaning
// IDLE  | loaded, not counting
// RUN   | decrementing on each qualified x
// PAUSE | frozen mid-count
// DONE  | reached 00, holds until load/reset
module bcd2_down_timer (
  input  logic                     clk,
  input  logic                     reset,
  bcd2_down_timer_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       done_q, done_d;
  logic [7:0] load_clamped;
  logic [7:0] count_dec;

  // Out-of-range digits saturate at 9 so the count is always valid BCD.
  always_comb begin
    load_clamped[7:4] = (bus.load_val[7:4] > 4'd9) ? 4'd9 : bus.load_val[7:4];
    load_clamped[3:0] = (bus.load_val[3:0] > 4'd9) ? 4'd9 : bus.load_val[3:0];
  end

  always_comb begin
    count_dec = count_q;
    if (count_q[3:0] != 4'd0) begin
      count_dec[3:0] = count_q[3:0] - 4'd1;
    end else begin
      count_dec[3:0] = 4'd9;
      count_dec[7:4] = count_q[7:4] - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d = load_clamped;
        end else if (bus.start && (count_q != 8'h00)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Load is ignored while running; stop outranks a same-cycle x.
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (bus.x && (count_q != 8'h00)) begin
          count_d = count_dec;
          if (count_q == 8'h01) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.load) begin
          count_d = load_clamped;
          state_d = IDLE;
        end else if (!bus.stop && bus.start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.load) begin
          count_d = load_clamped;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.bcd2_out = count_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd2_down_timer.sv
// Directed bench for bcd2_down_timer: linear steps, hand-computed expectations.
module tb_bcd2_down_timer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  bcd2_down_timer_if bus ();

  bcd2_down_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic i_x, input logic i_load, input logic [7:0] i_val,
                      input logic i_start, input logic i_stop, input logic i_reset);
    bus.x        = i_x;
    bus.load     = i_load;
    bus.load_val = i_val;
    bus.start    = i_start;
    bus.stop     = i_stop;
    reset        = i_reset;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_out,
                     input logic exp_run, input logic exp_done);
    n_cmp++;
    assert ({bus.bcd2_out, bus.running, bus.done} === {exp_out, exp_run, exp_done})
    else begin
      n_err++;
      $error("FAIL %s: got out=%h run=%b done=%b, expected out=%h run=%b done=%b",
             tag, bus.bcd2_out, bus.running, bus.done, exp_out, exp_run, exp_done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    step(0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'h37, 1, 0, 1);
    chk("reset", 8'h00, 0, 0);

    // load and borrow
    step(0, 1, 8'h21, 0, 0, 0);   chk("load21", 8'h21, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start21", 8'h21, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("dec20", 8'h20, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("borrow19", 8'h19, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("dec18", 8'h18, 1, 0);
    step(0, 0, 8'h00, 0, 0, 0);   chk("hold18", 8'h18, 1, 0);

    // terminal count
    step(0, 0, 8'h00, 0, 1, 0);   chk("stop18", 8'h18, 0, 0);
    step(0, 1, 8'h02, 0, 0, 0);   chk("load02", 8'h02, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start02", 8'h02, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("dec01", 8'h01, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("final00", 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 0, 0);   chk("hold00", 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);   chk("done_ign", 8'h00, 0, 0);

    // pause/resume
    step(0, 1, 8'h50, 0, 0, 0);   chk("load50", 8'h50, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start50", 8'h50, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("borrow49", 8'h49, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("dec48", 8'h48, 1, 0);
    step(1, 0, 8'h00, 1, 1, 0);   chk("stopwins", 8'h48, 0, 0);
    step(1, 0, 8'h00, 1, 1, 0);   chk("pause_stop", 8'h48, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("pause_x", 8'h48, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("resume", 8'h48, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);   chk("dec47", 8'h47, 1, 0);

    // clamp and ignore
    step(0, 0, 8'h00, 0, 1, 0);   chk("stop47", 8'h47, 0, 0);
    step(0, 1, 8'hAC, 0, 0, 0);   chk("clampAC", 8'h99, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start99", 8'h99, 1, 0);
    step(1, 1, 8'h10, 0, 0, 0);   chk("load_in_run", 8'h98, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);   chk("stop98", 8'h98, 0, 0);
    step(0, 1, 8'hFF, 0, 0, 0);   chk("clampFF", 8'h99, 0, 0);
    step(0, 1, 8'h3B, 0, 0, 0);   chk("clamp3B", 8'h39, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0);   chk("load00", 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start_zero", 8'h00, 0, 0);

    // reset mid-run at 01 with x high
    step(0, 1, 8'h01, 0, 0, 0);   chk("load01", 8'h01, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start01", 8'h01, 1, 0);
    step(1, 0, 8'h00, 0, 0, 1);   chk("reset_run", 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);   chk("no_done", 8'h00, 0, 0);

    // load alongside final x in RUN is ignored
    step(0, 1, 8'h01, 0, 0, 0);   chk("load01b", 8'h01, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);   chk("start01b", 8'h01, 1, 0);
    step(1, 1, 8'h55, 0, 0, 0);   chk("final_load", 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0, 0);   chk("done_fall", 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
